// File: rtl/key_reader.sv
// Key scanner handshake front-end feeding a first-word-fall-through code FIFO.
// Optional hex digit accumulator enabled by defining KEY_READER_HEX_EN.
module key_reader #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Key_ready,
    input  logic [4:0]  Key_out,
    output logic        readn,
    input  logic        rd_en,
    output logic [4:0]  key_code,
    output logic        key_valid,
    output logic [4:0]  fifo_cnt,
    output logic        overflow,
    input  logic        clr_ovf,
    output logic [31:0] hex_value
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_CLR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          readn_q, readn_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [4:0]    mem_q [DEPTH];

    logic capture_s;
    logic full_s;
    logic empty_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Handshake sequencing and FIFO bookkeeping; a pop in the same cycle frees a full slot.
    always_comb begin
        capture_s = (state_q == ST_IDLE) && Key_ready;
        full_s    = (cnt_q == DEPTH_C);
        empty_s   = (cnt_q == 5'd0);
        pop_s     = rd_en && !empty_s;
        push_s    = capture_s && (!full_s || pop_s);
        drop_s    = capture_s && full_s && !pop_s;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Key_ready) state_d = ST_ACK;
                else           state_d = ST_IDLE;
            end
            ST_ACK:      state_d = ST_WAIT_CLR;
            ST_WAIT_CLR: begin
                if (!Key_ready) state_d = ST_IDLE;
                else            state_d = ST_WAIT_CLR;
            end
            default:     state_d = ST_IDLE;
        endcase
        readn_d = (state_d != ST_ACK);

        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase

        if (drop_s)       ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            readn_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 5'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            readn_q  <= readn_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q] <= Key_out;
        end
    end

    assign readn     = readn_q;
    assign key_valid = !empty_s;
    assign key_code  = empty_s ? 5'd0 : mem_q[rd_ptr_q];
    assign fifo_cnt  = cnt_q;
    assign overflow  = ovf_q;

`ifdef KEY_READER_HEX_EN
    logic [31:0] hex_q, hex_d;

    // Digit entry tracks every accepted capture, even when the FIFO drops the code.
    always_comb begin
        hex_d = hex_q;
        if (capture_s) begin
            if (!Key_out[4]) begin
                hex_d = {hex_q[27:0], Key_out[3:0]};
            end else begin
                case (Key_out)
                    5'h10:   hex_d = {4'h0, hex_q[31:4]};
                    5'h11:   hex_d = 32'h0000_0000;
                    default: hex_d = hex_q;
                endcase
            end
        end else begin
            hex_d = hex_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) hex_q <= 32'h0000_0000;
        else     hex_q <= hex_d;
    end

    assign hex_value = hex_q;
`else
    assign hex_value = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_key_reader.sv
// Scoreboard bench for key_reader: expected codes queued at capture, compared at pop.
module tb_key_reader;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        Key_ready;
    logic [4:0]  Key_out;
    logic        readn;
    logic        rd_en;
    logic [4:0]  key_code;
    logic        key_valid;
    logic [4:0]  fifo_cnt;
    logic        overflow;
    logic        clr_ovf;
    logic [31:0] hex_value;

    int          n_total;
    int          n_bad;
    logic [4:0]  sb_q[$];
    logic        m_ovf;
    logic [31:0] m_hex;

    key_reader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .Key_ready (Key_ready),
        .Key_out   (Key_out),
        .readn     (readn),
        .rd_en     (rd_en),
        .key_code  (key_code),
        .key_valid (key_valid),
        .fifo_cnt  (fifo_cnt),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .hex_value (hex_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_capture(input logic [4:0] code, input bit pop);
        if (pop && sb_q.size() > 0) void'(sb_q.pop_front());
        if (sb_q.size() < DEPTH) sb_q.push_back(code);
        else m_ovf = 1'b1;
`ifdef KEY_READER_HEX_EN
        if (code < 5'h10)      m_hex = {m_hex[27:0], code[3:0]};
        else if (code == 5'h10) m_hex = {4'h0, m_hex[31:4]};
        else if (code == 5'h11) m_hex = 32'h0;
`endif
    endtask

    // One full key press starting and ending with the DUT idle, sampled just after an edge.
    task automatic key_cycle(input logic [4:0] code, input bit pop, input bit clr, input int hold);
        Key_out   = code;
        Key_ready = 1'b1;
        rd_en     = pop;
        clr_ovf   = clr;
        if (pop && sb_q.size() > 0) begin
            n_total++;
            if (key_code !== sb_q[0]) begin
                n_bad++;
                $display("FAIL kc_pop_head got=%h exp=%h", key_code, sb_q[0]);
            end
        end
        if (!(sb_q.size() == DEPTH && !pop) && clr) m_ovf = 1'b0;
        model_capture(code, pop);
        tick();
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        n_total++;
        if (readn !== 1'b0) begin
            n_bad++;
            $display("FAIL kc_readn_low got=%b exp=0", readn);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_total++;
            if (readn !== 1'b1) begin
                n_bad++;
                $display("FAIL kc_readn_high got=%b exp=1", readn);
            end
        end
        Key_ready = 1'b0;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && sb_q.size() > 0; i++) begin
            n_total++;
            if (key_valid !== 1'b1 || key_code !== sb_q[0] || fifo_cnt !== 5'(sb_q.size())) begin
                n_bad++;
                $display("FAIL drain got v=%b code=%h cnt=%0d exp v=1 code=%h cnt=%0d",
                         key_valid, key_code, fifo_cnt, sb_q[0], sb_q.size());
            end
            rd_en = 1'b1;
            void'(sb_q.pop_front());
            tick();
            rd_en = 1'b0;
        end
        n_total++;
        if (key_valid !== 1'b0 || key_code !== 5'd0 || fifo_cnt !== 5'd0) begin
            n_bad++;
            $display("FAIL drain_empty got v=%b code=%h cnt=%0d exp v=0 code=00 cnt=0",
                     key_valid, key_code, fifo_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        Key_ready = 1'b0; Key_out = 5'd0; rd_en = 1'b1; clr_ovf = 1'b1;
        repeat (3) tick();
        n_total++;
        if (readn !== 1'b1 || key_valid !== 1'b0 || key_code !== 5'd0 || fifo_cnt !== 5'd0 ||
            overflow !== 1'b0 || hex_value !== 32'h0) begin
            n_bad++;
            $display("FAIL reset got readn=%b v=%b code=%h cnt=%0d ovf=%b hex=%h exp 1 0 00 0 0 0",
                     readn, key_valid, key_code, fifo_cnt, overflow, hex_value);
        end
        rd_en = 1'b0; clr_ovf = 1'b0;
        rst = 1'b0;
        sb_q.delete(); m_ovf = 1'b0; m_hex = 32'h0;
        tick();
    endtask

    task automatic test_held_key();
        int lows;
        lows = 0;
        Key_out = 5'h05; Key_ready = 1'b1;
        model_capture(5'h05, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (readn === 1'b0) lows++;
            if (i == 0) begin
                n_total++;
                if (key_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL held_valid_latency got=%b exp=1", key_valid);
                end
            end
        end
        n_total++;
        if (lows != 1 || fifo_cnt !== 5'd1 || key_code !== 5'h05) begin
            n_bad++;
            $display("FAIL held_key got lows=%0d cnt=%0d code=%h exp lows=1 cnt=1 code=05",
                     lows, fifo_cnt, key_code);
        end
        Key_ready = 1'b0;
        tick();
        drain();
    endtask

    task automatic test_hex();
        logic [4:0] codes[5];
        codes = '{5'h01, 5'h02, 5'h03, 5'h10, 5'h0A};
        foreach (codes[i]) key_cycle(codes[i], 1'b0, 1'b0, 1);
        n_total++;
        if (hex_value !== m_hex) begin
            n_bad++;
            $display("FAIL hex_model got=%h exp=%h", hex_value, m_hex);
        end
`ifdef KEY_READER_HEX_EN
        n_total++;
        if (hex_value !== 32'h0000_012A) begin
            n_bad++;
            $display("FAIL hex_entry got=%h exp=0000012a", hex_value);
        end
`endif
        key_cycle(5'h11, 1'b0, 1'b0, 2);
        n_total++;
        if (hex_value !== 32'h0) begin
            n_bad++;
            $display("FAIL hex_clear got=%h exp=00000000", hex_value);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) key_cycle(5'(i + 1), 1'b0, 1'b0, 1);
        n_total++;
        if (fifo_cnt !== 5'd8 || overflow !== 1'b1 || key_code !== 5'h01 || m_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_full got cnt=%0d ovf=%b code=%h exp cnt=8 ovf=1 code=01",
                     fifo_cnt, overflow, key_code);
        end
        clr_ovf = 1'b1; m_ovf = 1'b0;
        tick();
        clr_ovf = 1'b0;
        n_total++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
        key_cycle(5'h0C, 1'b0, 1'b1, 1);
        n_total++;
        if (overflow !== 1'b1 || fifo_cnt !== 5'd8) begin
            n_bad++;
            $display("FAIL ovf_drop_wins got ovf=%b cnt=%0d exp ovf=1 cnt=8", overflow, fifo_cnt);
        end
        clr_ovf = 1'b1; m_ovf = 1'b0;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic test_full_push_pop();
        key_cycle(5'h1E, 1'b1, 1'b0, 1);
        n_total++;
        if (fifo_cnt !== 5'd8 || overflow !== 1'b0 || key_code !== 5'h02 || key_code !== sb_q[0]) begin
            n_bad++;
            $display("FAIL full_push_pop got cnt=%0d ovf=%b code=%h exp cnt=8 ovf=0 code=02",
                     fifo_cnt, overflow, key_code);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int lows;
        Key_out = 5'h07; Key_ready = 1'b1;
        model_capture(5'h07, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        sb_q.delete(); m_ovf = 1'b0; m_hex = 32'h0;
        tick();
        n_total++;
        if (fifo_cnt !== 5'd0 || readn !== 1'b1 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst got cnt=%0d readn=%b v=%b exp 0 1 0", fifo_cnt, readn, key_valid);
        end
        rst = 1'b0;
        model_capture(5'h07, 1'b0);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (readn === 1'b0) lows++;
        end
        n_total++;
        if (lows != 1 || fifo_cnt !== 5'd1 || key_code !== 5'h07) begin
            n_bad++;
            $display("FAIL mid_rst_recapture got lows=%0d cnt=%0d code=%h exp lows=1 cnt=1 code=07",
                     lows, fifo_cnt, key_code);
        end
        Key_ready = 1'b0;
        tick();
        drain();
    endtask

    task automatic test_empty_pop();
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (fifo_cnt !== 5'd0 || key_valid !== 1'b0 || key_code !== 5'd0) begin
                n_bad++;
                $display("FAIL empty_pop got cnt=%0d v=%b code=%h exp 0 0 00", fifo_cnt, key_valid, key_code);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            key_cycle(5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0), 1'b0, $urandom_range(1, 3));
            n_total++;
            if (fifo_cnt !== 5'(sb_q.size()) || overflow !== m_ovf || hex_value !== m_hex) begin
                n_bad++;
                $display("FAIL b2b got cnt=%0d ovf=%b hex=%h exp cnt=%0d ovf=%b hex=%h",
                         fifo_cnt, overflow, hex_value, sb_q.size(), m_ovf, m_hex);
            end
        end
        drain();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_held_key();
        test_hex();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_empty_pop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Key_ready  input  1  high while the scanner holds a valid key code.
REQ-005 Key_out  input  5  scan code from the scanner; valid while Key_ready=1.
REQ-006 readn  output  1  active-low read acknowledge to the scanner.
REQ-007 rd_en  input  1  consumer pop request.
REQ-008 key_code  output  5  FIFO head (first-word-fall-through).
REQ-009 key_valid  output  1  FIFO non-empty.
REQ-010 fifo_cnt  output  5  current FIFO occupancy, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag: a code was dropped.
REQ-012 clr_ovf  input  1  clears overflow.
REQ-013 hex_value  output  32  accumulated hex digit entry.

Function
REQ-014 Handshake FSM SHALL have states IDLE, ACK, WAIT_CLR.
REQ-015 IDLE: on Key_ready=1, capture Key_out and push it to the FIFO in that same edge; next state ACK.
REQ-016 ACK: readn=0 for exactly one cycle; next state WAIT_CLR.
REQ-017 WAIT_CLR: readn=1; remain until Key_ready=0, then IDLE; a held key SHALL yield exactly one push.
REQ-018 readn SHALL be 1 in IDLE and WAIT_CLR.
REQ-019 Capture-to-readn-low latency SHALL be 1 cycle; capture-to-key_valid latency 1 cycle when the FIFO was empty.
REQ-020 Pop: rd_en=1 with key_valid=1 removes head; rd_en with FIFO empty SHALL be ignored, no state change.
REQ-021 Push and pop in the same cycle: both performed; fifo_cnt unchanged; legal when full (pop frees the slot).
REQ-022 Push when full without pop: code dropped, FIFO unchanged, overflow set to 1.
REQ-023 overflow SHALL clear on clr_ovf=1 unless a drop occurs in the same cycle; then it stays 1.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; fifo_cnt SHALL never exceed DEPTH or go below 0.
REQ-025 key_code SHALL be 0 when key_valid=0.
REQ-026 hex_value SHALL update on each accepted capture (REQ-015), independent of FIFO fullness.
REQ-027 Code 0x00-0x0F: hex_value <= {hex_value[27:0], code[3:0]}; oldest digit discarded.
REQ-028 Code 0x10 (backspace): hex_value <= {4'h0, hex_value[31:4]}.
REQ-029 Code 0x11 (clear): hex_value <= 0; codes 0x12-0x1F: hex_value unchanged.

Reset
REQ-030 rst=1 SHALL force: FSM IDLE, readn=1, FIFO empty, fifo_cnt=0, key_valid=0, key_code=0, overflow=0, hex_value=0.
REQ-031 rst asserted mid-handshake (ACK/WAIT_CLR) SHALL return to IDLE; if Key_ready is still 1 after release, the code SHALL be captured again as a new key.
REQ-032 rst SHALL have priority over every other input, including rd_en and clr_ovf.

Configuration
REQ-033 Macro KEY_READER_HEX_EN SHALL gate the hex accumulator.
REQ-034 Defined: REQ-026..REQ-029 are in effect.
REQ-035 Undefined: hex_value is constant 0 and no accumulator registers are generated; FIFO and handshake are unchanged.

Verification
REQ-036 Key_ready=1 with Key_out=0x05 held 20 cycles -> one push, readn low for exactly 1 cycle, key_code=0x05, fifo_cnt=1.
REQ-037 Codes 0x1,0x2,0x3,0x10,0xA entered (HEX_EN defined) -> hex_value=0x0000012A; then 0x11 -> hex_value=0.
REQ-038 9 keys entered with DEPTH=8, no pops -> fifo_cnt=8, overflow=1, key_code=first code; clr_ovf pulse -> overflow=0.
REQ-039 FIFO full, key capture and rd_en in the same cycle -> fifo_cnt stays 8, overflow stays 0, head advances to the second code.
REQ-040 rst pulsed during WAIT_CLR with Key_ready held at 0x07 -> after release one new push of 0x07, fifo_cnt=1, readn low 1 cycle.
REQ-041 rd_en=1 with FIFO empty for 5 cycles -> fifo_cnt=0, key_valid=0, key_code=0.
